med_keypad_scanner: RTL and testbench

MED_KEYPAD_SCANNER -- requirements
Module: med_keypad_scanner

---
 rtl/med_reminder_pkg.sv | 61 ++++++
 rtl/sync_2ff.sv | 25 ++
 rtl/med_keypad_scanner.sv | 131 +++++++++++++
 tb/tb_med_keypad_scanner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/med_reminder_pkg.sv
// Shared definitions for the reminder keypad front end: scanner states,
// key_out field layout, named key codes and small row/column helpers.
package med_reminder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_PRESSED  = 3'd3,
        ST_RELEASE  = 3'd4
    } scan_state_t;

    localparam int unsigned KEY_OUT_W      = 8;
    localparam int unsigned KEY_STROBE_BIT = 7;
    localparam int unsigned KEY_CODE_MSB   = 3;
    localparam int unsigned KEY_CODE_LSB   = 0;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_SNOOZE  = 4'hB;
    localparam logic [3:0] KEY_CANCEL  = 4'hC;

    // Active-low one-hot pattern with bit idx low.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // True when exactly one row reads low.
    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        hit = 1'b0;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Strobed key word; code = row*4 + col.
    function automatic logic [KEY_OUT_W-1:0] make_key(input logic [1:0] row,
                                                      input logic [1:0] col);
        logic [KEY_OUT_W-1:0] key;
        key = '0;
        key[KEY_STROBE_BIT] = 1'b1;
        key[KEY_CODE_MSB:KEY_CODE_LSB] = {row, col};
        return key;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a
// configurable reset value.
module sync_2ff #(
    parameter int unsigned        WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/med_keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce, ghost rejection
// and a single one-cycle strobe per key press.
module med_keypad_scanner
    import med_reminder_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] key_out,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state;
    logic [3:0]       rows_s;
    logic [1:0]       col;
    logic [1:0]       next_col;
    logic [1:0]       key_row;
    logic [1:0]       key_col;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (rows_s)
    );

    assign next_col = col + 2'd1;

    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            state    <= ST_IDLE;
            col_n    <= 4'hF;
            key_out  <= '0;
            key_held <= 1'b0;
            col      <= '0;
            key_row  <= '0;
            key_col  <= '0;
            div_cnt  <= '0;
            deb_cnt  <= '0;
        end else begin
            key_out <= '0;
            unique case (state)
                ST_IDLE: begin
                    state   <= ST_SCAN;
                    col     <= 2'd0;
                    col_n   <= one_cold(2'd0);
                    div_cnt <= '0;
                    deb_cnt <= '0;
                end

                ST_SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (single_low(rows_s)) begin
                            key_row <= low_index(rows_s);
                            key_col <= col;
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col   <= next_col;
                            col_n <= one_cold(next_col);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // Column stays driven while the press is confirmed; col still
                // equals key_col, so next_col resumes rotation after it.
                ST_DEBOUNCE: begin
                    if (rows_s != one_cold(key_row)) begin
                        deb_cnt <= '0;
                        col     <= next_col;
                        col_n   <= one_cold(next_col);
                        state   <= ST_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        key_out  <= make_key(key_row, key_col);
                        key_held <= 1'b1;
                        state    <= ST_PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (rows_s[key_row]) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!rows_s[key_row]) begin
                        deb_cnt <= '0;
                        state   <= ST_PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        key_held <= 1'b0;
                        col      <= next_col;
                        col_n    <= one_cold(next_col);
                        state    <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    col_n <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_med_keypad_scanner.sv
// Directed bench for med_keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=3.
module tb_med_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [7:0] key_out;
    logic       key_held;

    int         total = 0;
    int         bad   = 0;
    int         nz_cnt = 0;
    logic [7:0] last_key = 8'h00;

    always #5 clk = ~clk;

    med_keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_out  (key_out),
        .key_held (key_held)
    );

    // Records every cycle on which key_out is non-zero.
    always @(negedge clk) begin
        if (key_out !== 8'h00) begin
            nz_cnt   = nz_cnt + 1;
            last_key = key_out;
        end
    end

    task automatic wait_col(input logic [3:0] c, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (col_n === c) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b1; row_n = 4'hF;
        repeat (2) @(negedge clk);
        total++; if (col_n !== 4'hF) begin bad++; $display("FAIL reset_col: got %h want f", col_n); end
        total++; if (key_out !== 8'h00) begin bad++; $display("FAIL reset_key: got %h want 00", key_out); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL reset_first_col: got %b want 1110", col_n); end
        total++; if (key_out !== 8'h00) begin bad++; $display("FAIL reset_no_strobe: got %h want 00", key_out); end
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'b1101) begin bad++; $display("FAIL scan_dwell: got %b want 1101", col_n); end
    endtask

    task automatic test_clean_press;
        int n0;
        bit ok;
        n0 = nz_cnt;
        wait_col(4'b1011, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL press_wait_col: got timeout want col2"); end
        row_n = 4'b1101;
        repeat (40) @(negedge clk);
        total++; if (col_n !== 4'b1011) begin bad++; $display("FAIL press_col_hold: got %b want 1011", col_n); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
        total++; if (nz_cnt - n0 !== 1) begin bad++; $display("FAIL press_strobe_cycles: got %0d want 1", nz_cnt - n0); end
        total++; if (last_key !== 8'h86) begin bad++; $display("FAIL press_code: got %h want 86", last_key); end
        row_n = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++; if (key_held !== 1'b1) begin bad++; $display("FAIL release_hold_%0d: got %b want 1", i, key_held); end
        end
        @(negedge clk);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_done: got %b want 0", key_held); end
        total++; if (col_n !== 4'b0111) begin bad++; $display("FAIL release_next_col: got %b want 0111", col_n); end
    endtask

    task automatic test_bounce;
        int n0;
        bit ok;
        n0 = nz_cnt;
        wait_col(4'b1011, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL bounce_wait_col: got timeout want col2"); end
        row_n = 4'b1101;
        repeat (4) @(negedge clk);
        row_n = 4'hF;
        repeat (2) @(negedge clk);
        total++; if (col_n !== 4'b1011) begin bad++; $display("FAIL bounce_col_stopped: got %b want 1011", col_n); end
        @(negedge clk);
        total++; if (col_n !== 4'b0111) begin bad++; $display("FAIL bounce_resume: got %b want 0111", col_n); end
        repeat (3) @(negedge clk);
        total++; if (nz_cnt - n0 !== 0) begin bad++; $display("FAIL bounce_strobe: got %0d want 0", nz_cnt - n0); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b want 0", key_held); end
    endtask

    task automatic test_ghost;
        int n0;
        bit ok;
        n0 = nz_cnt;
        wait_col(4'b1101, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL ghost_wait_col: got timeout want col1"); end
        row_n = 4'b0110;
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'b1011) begin bad++; $display("FAIL ghost_col2: got %b want 1011", col_n); end
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'b0111) begin bad++; $display("FAIL ghost_col3: got %b want 0111", col_n); end
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL ghost_col0: got %b want 1110", col_n); end
        row_n = 4'hF;
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'b1101) begin bad++; $display("FAIL ghost_col1: got %b want 1101", col_n); end
        total++; if (nz_cnt - n0 !== 0) begin bad++; $display("FAIL ghost_strobe: got %0d want 0", nz_cnt - n0); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held: got %b want 0", key_held); end
    endtask

    task automatic test_release_glitch;
        int n0;
        bit ok;
        bit got;
        n0 = nz_cnt;
        wait_col(4'b1011, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL glitch_wait_col: got timeout want col2"); end
        row_n = 4'b1101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (key_out[7]) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL glitch_strobe_seen: got timeout want strobe"); end
        else begin
            total++; if (key_out !== 8'h86) begin bad++; $display("FAIL glitch_code: got %h want 86", key_out); end
        end
        repeat (5) @(negedge clk);
        row_n = 4'hF;
        @(negedge clk);
        row_n = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held_%0d: got %b want 1", i, key_held); end
        end
        row_n = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL glitch_release: got timeout want held=0"); end
        total++; if (nz_cnt - n0 !== 1) begin bad++; $display("FAIL glitch_strobes: got %0d want 1", nz_cnt - n0); end
    endtask

    task automatic test_abort_rst;
        bit ok;
        bit got;
        wait_col(4'b1011, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL arst_wait_col: got timeout want col2"); end
        row_n = 4'b1101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (key_out[7]) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL arst_strobe_seen: got timeout want strobe"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL arst_held: got %b want 0", key_held); end
        total++; if (key_out !== 8'h00) begin bad++; $display("FAIL arst_key: got %h want 00", key_out); end
        total++; if (col_n !== 4'hF) begin bad++; $display("FAIL arst_col: got %b want 1111", col_n); end
        row_n = 4'hF;
        rst = 1'b0;
        @(negedge clk);
        total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL arst_restart: got %b want 1110", col_n); end
    endtask

    task automatic test_abort_ena;
        bit ok;
        bit got;
        wait_col(4'b1011, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL aena_wait_col: got timeout want col2"); end
        row_n = 4'b1101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (key_out[7]) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL aena_strobe_seen: got timeout want strobe"); end
        repeat (2) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL aena_held: got %b want 0", key_held); end
        total++; if (key_out !== 8'h00) begin bad++; $display("FAIL aena_key: got %h want 00", key_out); end
        total++; if (col_n !== 4'hF) begin bad++; $display("FAIL aena_col: got %b want 1111", col_n); end
        row_n = 4'hF;
        repeat (4) @(negedge clk);
        total++; if (col_n !== 4'hF) begin bad++; $display("FAIL aena_idle: got %b want 1111", col_n); end
        ena = 1'b1;
        @(negedge clk);
        total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL aena_restart: got %b want 1110", col_n); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; row_n = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_release_glitch();
        test_abort_rst();
        test_abort_ena();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
